// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: generates A/B/index channels and a signed position
// count, either at a fixed velocity or as a move to a target count.
module quad_encoder_emulator #(
  parameter int unsigned CPR        = 4096,
  parameter int unsigned MIN_PERIOD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               mode,
  input  logic               direction,
  input  logic [23:0]        step_period,
  input  logic signed [31:0] target_pos,
  input  logic               load,
  input  logic signed [31:0] load_pos,
  output logic               enc_a,
  output logic               enc_b,
  output logic               enc_index,
  output logic signed [31:0] emu_position,
  output logic               at_target,
  output logic               move_done
);

  localparam int unsigned PW = 24;
  localparam int unsigned AW = $clog2(CPR + 1);

  logic [PW-1:0]      r_cnt;
  logic [PW-1:0]      r_eff;
  logic               r_step;
  logic               r_enc_a;
  logic               r_enc_b;
  logic               r_index;
  logic [AW-1:0]      r_angle;
  logic signed [31:0] r_pos;
  logic               r_at_target;
  logic               r_move_done;

  logic [PW-1:0]      w_eff_req;
  logic [PW-1:0]      w_eff;
  logic               w_pending;
  logic               w_fwd;
  logic               w_terminal;
  logic               w_apply;
  logic [1:0]         w_phase;
  logic [1:0]         w_phase_next;
  logic [AW-1:0]      w_angle_next;
  logic signed [31:0] w_pos_next;

  // Period is latched at the start of each period (counter at 0).
  assign w_eff_req = (step_period < PW'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : step_period;
  assign w_eff     = (r_cnt == '0) ? w_eff_req : r_eff;

  assign w_pending  = enable && (!mode || (r_pos != target_pos));
  assign w_fwd      = mode ? (target_pos > r_pos) : direction;
  assign w_terminal = w_pending && (r_cnt == (w_eff - PW'(1)));
  // Pending-ness is re-checked when the step lands so a target change cannot overshoot.
  assign w_apply    = r_step && w_pending && !load;

  // Gray phase index: 00 -> 10 -> 11 -> 01 maps to 0,1,2,3.
  assign w_phase      = {r_enc_b, r_enc_a ^ r_enc_b};
  assign w_phase_next = w_phase + (w_fwd ? 2'd1 : 2'd3);

  always_comb begin
    w_angle_next = r_angle;
    if (w_apply) begin
      if (w_fwd) begin
        w_angle_next = (r_angle == AW'(CPR - 1)) ? '0 : r_angle + AW'(1);
      end else begin
        w_angle_next = (r_angle == '0) ? AW'(CPR - 1) : r_angle - AW'(1);
      end
    end
  end

  always_comb begin
    w_pos_next = r_pos;
    if (load) begin
      w_pos_next = load_pos;
    end else if (w_apply) begin
      w_pos_next = w_fwd ? (r_pos + 32'sd1) : (r_pos - 32'sd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_eff       <= PW'(MIN_PERIOD);
      r_step      <= 1'b0;
      r_enc_a     <= 1'b0;
      r_enc_b     <= 1'b0;
      r_index     <= 1'b1;
      r_angle     <= '0;
      r_pos       <= '0;
      r_at_target <= 1'b0;
      r_move_done <= 1'b0;
    end else begin
      r_eff <= w_eff;
      if (load || !w_pending) begin
        r_cnt  <= '0;
        r_step <= 1'b0;
      end else if (w_terminal) begin
        r_cnt  <= '0;
        r_step <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + PW'(1);
        r_step <= 1'b0;
      end

      if (w_apply) begin
        r_enc_a <= w_phase_next[1] ^ w_phase_next[0];
        r_enc_b <= w_phase_next[1];
        r_angle <= w_angle_next;
        r_index <= (w_angle_next == '0);
      end

      r_pos       <= w_pos_next;
      r_at_target <= mode && (w_pos_next == target_pos);
      r_move_done <= w_apply && mode && (w_pos_next == target_pos);
    end
  end

  assign enc_a        = r_enc_a;
  assign enc_b        = r_enc_b;
  assign enc_index    = r_index;
  assign emu_position = r_pos;
  assign at_target    = r_at_target;
  assign move_done    = r_move_done;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Scoreboard bench for quad_encoder_emulator: stimulus tasks predict every output
// change from a step-schedule model; a negedge monitor matches observed changes.
module tb_quad_encoder_emulator;

  localparam int CPR  = 8;
  localparam int MINP = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               mode = 1'b0;
  logic               direction = 1'b0;
  logic [23:0]        step_period = 24'd0;
  logic signed [31:0] target_pos = 32'sd0;
  logic               load = 1'b0;
  logic signed [31:0] load_pos = 32'sd0;
  logic               enc_a, enc_b, enc_index;
  logic signed [31:0] emu_position;
  logic               at_target, move_done;

  quad_encoder_emulator #(.CPR(CPR), .MIN_PERIOD(MINP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .direction(direction),
    .step_period(step_period), .target_pos(target_pos), .load(load), .load_pos(load_pos),
    .enc_a(enc_a), .enc_b(enc_b), .enc_index(enc_index), .emu_position(emu_position),
    .at_target(at_target), .move_done(move_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic a;
    logic b;
    logic idx;
    int   pos;
    logic md;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  idx_hits = 0;
  int  md_hits = 0;
  bit  mon_on = 0;

  // Reference state: count, quadrature phase (0..3 along 00,10,11,01) and angle.
  int m_pos = 0;
  int m_phase = 0;
  int m_angle = 0;
  bit seq_a [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  bit seq_b [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  task automatic check(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void m_push(input int t, input bit md);
    ev_t e;
    e.cyc = t;
    e.a   = seq_a[m_phase];
    e.b   = seq_b[m_phase];
    e.idx = (m_angle == 0);
    e.pos = m_pos;
    e.md  = md;
    exp_q.push_back(e);
  endfunction

  function automatic void m_step(input bit fwd);
    m_pos   = fwd ? m_pos + 1 : m_pos - 1;
    m_phase = fwd ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
    m_angle = fwd ? (m_angle + 1) % CPR : (m_angle + CPR - 1) % CPR;
  endfunction

  // Monitor: any change of A, B or position must match the next predicted event.
  logic pa, pb;
  logic signed [31:0] ppos;
  ev_t mon_ev;
  always @(negedge clk) begin
    if (mon_on) begin
      if (enc_a !== pa || enc_b !== pb || emu_position !== ppos) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: cyc %0d ab=%b%b pos=%0d, expected no change",
                   cyc, enc_a, enc_b, emu_position);
        end else begin
          mon_ev = exp_q.pop_front();
          if (cyc != mon_ev.cyc || enc_a !== mon_ev.a || enc_b !== mon_ev.b ||
              enc_index !== mon_ev.idx || emu_position !== mon_ev.pos ||
              move_done !== mon_ev.md) begin
            fails++;
            $display("FAIL event: got cyc=%0d ab=%b%b idx=%b pos=%0d md=%b, expected cyc=%0d ab=%b%b idx=%b pos=%0d md=%b",
                     cyc, enc_a, enc_b, enc_index, emu_position, move_done,
                     mon_ev.cyc, mon_ev.a, mon_ev.b, mon_ev.idx, mon_ev.pos, mon_ev.md);
          end
          if (enc_index === 1'b1) idx_hits++;
          if (move_done === 1'b1) md_hits++;
        end
      end else if (move_done !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL spurious_move_done: cyc %0d got %b expected 0", cyc, move_done);
      end
    end
    pa   = enc_a;
    pb   = enc_b;
    ppos = emu_position;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // All tasks start and end just after a negedge.
  task automatic apply_reset(input bit chk);
    int r;
    reset = 1'b1;
    r = cyc + 1;
    if (mon_on && (m_pos != 0 || m_phase != 0)) begin
      m_pos = 0; m_phase = 0; m_angle = 0;
      m_push(r, 1'b0);
    end
    m_pos = 0; m_phase = 0; m_angle = 0;
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; mode = 1'b0; load = 1'b0;
    if (chk) begin
      check("rst_a", enc_a, 0);
      check("rst_b", enc_b, 0);
      check("rst_index", enc_index, 1);
      check("rst_pos", emu_position, 0);
      check("rst_at_target", at_target, 0);
      check("rst_move_done", move_done, 0);
    end
    idle(1);
  endtask

  function automatic int eff_of(input int p);
    return (p < MINP) ? MINP : p;
  endfunction

  function automatic int seg_of(input int i, input int seglen);
    return (i / seglen > 3) ? 3 : i / seglen;
  endfunction

  // Continuous velocity for n enabled clocks, direction per segment from dmask.
  task automatic run_vel(input int p, input int n, input int seglen, input logic [3:0] dmask);
    int e, eff;
    e = cyc + 1;
    eff = eff_of(p);
    for (int t = e + eff; t < e + n; t += eff) begin
      m_step(dmask[seg_of(t - e, seglen)]);
      m_push(t, 1'b0);
    end
    mode = 1'b0;
    step_period = 24'(p);
    for (int i = 0; i < n; i++) begin
      enable = 1'b1;
      direction = dmask[seg_of(i, seglen)];
      @(negedge clk);
    end
    enable = 1'b0;
    idle(2);
  endtask

  // Move to target for at most n enabled clocks; if rst is set, reset lands on clock n.
  task automatic run_move(input int p, input int tgt, input int n, input bit rst);
    int e, eff, t;
    e = cyc + 1;
    eff = eff_of(p);
    t = e + eff;
    while (m_pos != tgt && t < e + n) begin
      m_step(tgt > m_pos);
      m_push(t, m_pos == tgt);
      t += eff;
    end
    mode = 1'b1;
    target_pos = tgt;
    step_period = 24'(p);
    for (int i = 0; i < n; i++) begin
      enable = 1'b1;
      direction = 1'($urandom);
      @(negedge clk);
    end
    if (rst) begin
      apply_reset(1'b1);
    end else begin
      enable = 1'b0;
      idle(2);
    end
  endtask

  // Forward run with a load strobe on the k-th terminal-count clock.
  task automatic run_load_tc(input int p, input int k, input int n, input int lp);
    int e, eff, l;
    e = cyc + 1;
    eff = eff_of(p);
    l = e + k * eff - 1;
    for (int t = e + eff; t < l; t += eff) begin
      m_step(1'b1);
      m_push(t, 1'b0);
    end
    m_pos = lp;
    m_push(l, 1'b0);
    for (int t = l + 1 + eff; t < e + n; t += eff) begin
      m_step(1'b1);
      m_push(t, 1'b0);
    end
    mode = 1'b0;
    step_period = 24'(p);
    for (int i = 0; i < n; i++) begin
      enable = 1'b1;
      direction = 1'b1;
      load = (e + i == l);
      load_pos = lp;
      @(negedge clk);
    end
    enable = 1'b0;
    load = 1'b0;
    idle(2);
  endtask

  task automatic do_load(input int lp);
    load = 1'b1;
    load_pos = lp;
    m_pos = lp;
    m_push(cyc + 1, 1'b0);
    @(negedge clk);
    load = 1'b0;
    idle(1);
  endtask

  initial begin
    int p, n, d, tgt;
    @(negedge clk);
    apply_reset(1'b1);
    mon_on = 1;

    // Velocity mode, 10 clocks per edge for 400 clocks.
    run_vel(10, 400, 400, 4'b1111);
    check("vel400_pos", emu_position, 39);
    check("vel400_at_target", at_target, 0);

    // step_period 0 clamps to the minimum period.
    run_vel(0, 41, 41, 4'b1111);
    check("clamp_pos", emu_position, 49);

    // Index: forward 20 steps from 0 with CPR=8.
    apply_reset(1'b0);
    idx_hits = 0;
    run_vel(4, 81, 81, 4'b1111);
    check("index_fwd_hits", idx_hits, 2);
    check("index_fwd_pos", emu_position, 20);

    // Index: reverse from 1 through 0 and -8.
    apply_reset(1'b0);
    run_vel(4, 5, 5, 4'b1111);
    idx_hits = 0;
    run_vel(4, 41, 41, 4'b0000);
    check("index_rev_hits", idx_hits, 2);
    check("index_rev_pos", emu_position, -9);

    // Move to -5 from 0.
    apply_reset(1'b0);
    md_hits = 0;
    run_move(4, -5, 60, 1'b0);
    check("move_pos", emu_position, -5);
    check("move_at_target", at_target, 1);
    check("move_done_pulses", md_hits, 1);

    // Target already equal on entry: no step, no pulse.
    run_move(4, -5, 30, 1'b0);
    check("equal_entry_pulses", md_hits, 1);
    check("equal_entry_at_target", at_target, 1);

    // Preload to max positive, then one forward step wraps.
    do_load(32'h7FFF_FFFF);
    check("load_max", emu_position, 32'sh7FFF_FFFF);
    run_vel(4, 5, 5, 4'b1111);
    check("wrap_pos", emu_position, -64'sd2147483648);

    // Load coincident with a terminal count suppresses that step.
    run_load_tc(6, 3, 60, 1000);
    check("load_tc_pos", emu_position, 1000 + (60 - 19) / 6);

    // Randomized velocity runs with direction segments.
    for (int r = 0; r < 6; r++) begin
      p = $urandom_range(0, 12);
      n = $urandom_range(30, 150);
      run_vel(p, n, n / 4 + 1, 4'($urandom));
      check("rand_vel_pos", emu_position, m_pos);
    end

    // Randomized moves.
    for (int r = 0; r < 4; r++) begin
      p = $urandom_range(0, 10);
      d = $urandom_range(0, 30) - 15;
      tgt = m_pos + d;
      run_move(p, tgt, (d < 0 ? -d : d) * eff_of(p) + 10, 1'b0);
      check("rand_move_pos", emu_position, tgt);
      check("rand_move_at_target", at_target, 1);
    end

    // Reset landing on a step clock mid-move; nothing may follow it.
    apply_reset(1'b0);
    run_move(4, 50, 12, 1'b1);
    idle(20);
    check("post_reset_pos", emu_position, 0);
    check("post_reset_ab", {enc_a, enc_b}, 0);

    idle(5);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
